// File: rtl/alu_arbiter_pkg.sv
// +------------------------------------------------------------------+
// | alu_arbiter_pkg : opcodes, flag indices, FSM encoding, helpers    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package alu_arbiter_pkg;

  localparam logic [15:0] OP_AND  = 16'h0010;
  localparam logic [15:0] OP_OR   = 16'h0020;
  localparam logic [15:0] OP_XOR  = 16'h0030;
  localparam logic [15:0] OP_ADD  = 16'h0050;
  localparam logic [15:0] OP_SUB  = 16'h0060;
  localparam logic [15:0] OP_ADDC = 16'h0070;
  localparam logic [15:0] OP_SUBC = 16'h0080;
  localparam logic [15:0] OP_CMP  = 16'h00B0;

  // ZCVNL ordering of the flag word; N and L are produced only by CMP
  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_L = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_defined_op(input logic [15:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB,
      OP_ADDC, OP_SUBC, OP_CMP: is_defined_op = 1'b1;
      default:                 is_defined_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_if.sv
// +------------------------------------------------------------------+
// | alu_arbiter_if : two request channels, one response channel       |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic [15:0] req0_op;
  logic        req0_use_cin;
  logic        req0_wr_flags;

  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic [15:0] req1_op;
  logic        req1_use_cin;
  logic        req1_wr_flags;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_c;
  logic [4:0]  rsp_flags;
  logic [4:0]  psr;
  logic        busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_use_cin, req0_wr_flags,
    output req1_valid, req1_a, req1_b, req1_op, req1_use_cin, req1_wr_flags,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_c, rsp_flags, psr, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_use_cin, req0_wr_flags,
    input  req1_valid, req1_a, req1_b, req1_op, req1_use_cin, req1_wr_flags,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_c, rsp_flags, psr, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
// +------------------------------------------------------------------+
// | alu_arbiter_alu : combinational 16-bit ALU producing ZCVNL flags  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] op,
  input  logic        cin,
  output logic [15:0] c,
  output logic [4:0]  flags
);

  logic [16:0] wide;
  logic        cin_eff;

  always_comb begin
    c       = 16'h0000;
    flags   = 5'b00000;
    wide    = 17'd0;
    cin_eff = 1'b0;
    case (op)
      OP_AND: begin
        c             = a & b;
        flags[FLAG_Z] = (c == 16'h0000);
      end
      OP_OR: begin
        c             = a | b;
        flags[FLAG_Z] = (c == 16'h0000);
      end
      OP_XOR: begin
        c             = a ^ b;
        flags[FLAG_Z] = (c == 16'h0000);
      end
      OP_ADD, OP_ADDC: begin
        cin_eff       = (op == OP_ADDC) ? cin : 1'b0;
        wide          = {1'b0, a} + {1'b0, b} + {16'd0, cin_eff};
        c             = wide[15:0];
        flags[FLAG_C] = wide[16];
        flags[FLAG_V] = (a[15] == b[15]) && (c[15] != a[15]);
        flags[FLAG_Z] = (c == 16'h0000);
      end
      // C is a borrow for subtraction
      OP_SUB, OP_SUBC: begin
        cin_eff       = (op == OP_SUBC) ? cin : 1'b0;
        wide          = {1'b0, a} - {1'b0, b} - {16'd0, cin_eff};
        c             = wide[15:0];
        flags[FLAG_C] = wide[16];
        flags[FLAG_V] = (a[15] != b[15]) && (c[15] != a[15]);
        flags[FLAG_Z] = (c == 16'h0000);
      end
      // Compare writes no result, only Z and the signed/unsigned less-than flags
      OP_CMP: begin
        flags[FLAG_Z] = (a == b);
        flags[FLAG_N] = ($signed(a) < $signed(b));
        flags[FLAG_L] = (a < b);
      end
      default: begin
        c     = 16'h0000;
        flags = 5'b00000;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// +------------------------------------------------------------------+
// | alu_arbiter : two-requester arbiter in front of one shared ALU    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit         FAIR     = 1'b1,
  parameter logic [4:0] PSR_INIT = 5'b00000
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_arbiter_if.slave  bus
);

  state_e      state_q,      state_d;
  logic [15:0] a_q,          a_d;
  logic [15:0] b_q,          b_d;
  logic [15:0] op_q,         op_d;
  logic        use_cin_q,    use_cin_d;
  logic        wr_flags_q,   wr_flags_d;
  logic        id_q,         id_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] rsp_c_q,      rsp_c_d;
  logic [4:0]  rsp_flags_q,  rsp_flags_d;
  logic        rsp_id_q,     rsp_id_d;
  logic [4:0]  psr_q,        psr_d;

  logic        grant0;
  logic        grant1;
  logic        alu_cin;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;

  // last_grant_q == 1 means req1 went last, so req0 has the turn
  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~FAIR | last_grant_q);
  assign grant1 = bus.req1_valid & ~grant0;

  assign alu_cin = use_cin_q & psr_q[FLAG_C];

  alu_arbiter_alu u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .cin   (alu_cin),
    .c     (alu_c),
    .flags (alu_flags)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    use_cin_d    = use_cin_q;
    wr_flags_d   = wr_flags_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_c_d      = rsp_c_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_id_d     = rsp_id_q;
    psr_d        = psr_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0 | grant1) begin
          a_d          = grant1 ? bus.req1_a        : bus.req0_a;
          b_d          = grant1 ? bus.req1_b        : bus.req0_b;
          op_d         = grant1 ? bus.req1_op       : bus.req0_op;
          use_cin_d    = grant1 ? bus.req1_use_cin  : bus.req0_use_cin;
          wr_flags_d   = grant1 ? bus.req1_wr_flags : bus.req0_wr_flags;
          id_d         = grant1;
          last_grant_d = grant1;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_c_d     = alu_c;
        rsp_flags_d = alu_flags;
        rsp_id_d    = id_q;
        if (wr_flags_q && is_defined_op(op_q)) begin
          psr_d = alu_flags;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      op_q         <= 16'h0000;
      use_cin_q    <= 1'b0;
      wr_flags_q   <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_c_q      <= 16'h0000;
      rsp_flags_q  <= 5'b00000;
      rsp_id_q     <= 1'b0;
      psr_q        <= PSR_INIT;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      use_cin_q    <= use_cin_d;
      wr_flags_q   <= wr_flags_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_c_q      <= rsp_c_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_id_q     <= rsp_id_d;
      psr_q        <= psr_d;
    end
  end

  assign bus.req0_ready = reset_n & (state_q == ST_IDLE) & grant0;
  assign bus.req1_ready = reset_n & (state_q == ST_IDLE) & grant1;
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.psr        = psr_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// +------------------------------------------------------------------+
// | tb_alu_arbiter : directed self-checking bench for alu_arbiter     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic reset2_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  alu_arbiter_if bus ();
  alu_arbiter_if bus2 ();

  always #5 clk = ~clk;

  alu_arbiter #(.FAIR(1'b1), .PSR_INIT(5'b00000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  alu_arbiter #(.FAIR(1'b0), .PSR_INIT(5'b01000)) dut_fix (
    .clk     (clk),
    .reset_n (reset2_n),
    .bus     (bus2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input bit second, input string tag);
    int n = 0;
    while (!(second ? bus2.rsp_valid : bus.rsp_valid) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rsp_timeout"}, 32'(second ? bus2.rsp_valid : bus.rsp_valid), 32'(1));
  endtask

  task automatic issue(input bit id, input logic [15:0] op, input logic [15:0] a,
                       input logic [15:0] b, input bit cin, input bit wr, input string tag);
    int n = 0;
    if (id) begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      bus.req1_use_cin = cin; bus.req1_wr_flags = wr; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      bus.req0_use_cin = cin; bus.req0_wr_flags = wr; bus.req0_valid = 1'b1;
    end
    #1;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      tick();
      #1;
      n++;
    end
    check({tag, "_ready"}, 32'(id ? bus.req1_ready : bus.req0_ready), 32'(1));
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, output logic [15:0] c, output logic [4:0] f,
                         output logic id);
    bus.rsp_ready = 1'b1;
    wait_rsp(1'b0, tag);
    c  = bus.rsp_c;
    f  = bus.rsp_flags;
    id = bus.rsp_id;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  logic [15:0] c;
  logic [4:0]  f;
  logic        id;

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req0_use_cin = 1'b0; bus.req0_wr_flags = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.req1_use_cin = 1'b0; bus.req1_wr_flags = 1'b0;
    bus.rsp_ready = 1'b0;
    // second instance: fixed priority, both requesters permanently valid
    bus2.req0_valid = 1'b1; bus2.req0_a = 16'h00FF; bus2.req0_b = 16'h0F0F;
    bus2.req0_op = 16'h0010; bus2.req0_use_cin = 1'b0; bus2.req0_wr_flags = 1'b0;
    bus2.req1_valid = 1'b1; bus2.req1_a = 16'h00FF; bus2.req1_b = 16'h0F0F;
    bus2.req1_op = 16'h0020; bus2.req1_use_cin = 1'b0; bus2.req1_wr_flags = 1'b0;
    bus2.rsp_ready = 1'b1;

    // reset values, ready held low while in reset
    bus.req0_valid = 1'b1;
    tick(); tick();
    check("rst_ready0", 32'(bus.req0_ready), 32'(0));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_psr", 32'(bus.psr), 32'(0));
    check("rst_rsp_c", 32'(bus.rsp_c), 32'(0));
    check("rst_rsp_flags", 32'(bus.rsp_flags), 32'(0));
    check("rst_rsp_id", 32'(bus.rsp_id), 32'(0));
    bus.req0_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    // ADD 7FFF+0001: exact T / T+1 / T+2 timing
    bus.req0_op = 16'h0050; bus.req0_a = 16'h7FFF; bus.req0_b = 16'h0001;
    bus.req0_wr_flags = 1'b1; bus.req0_valid = 1'b1;
    #1;
    check("add_ready_T", 32'(bus.req0_ready), 32'(1));
    tick();
    bus.req0_valid = 1'b0;
    #1;
    check("add_busy_T1", 32'(bus.busy), 32'(1));
    check("add_rsp_valid_T1", 32'(bus.rsp_valid), 32'(0));
    check("add_ready_T1", 32'(bus.req0_ready), 32'(0));
    tick();
    check("add_rsp_valid_T2", 32'(bus.rsp_valid), 32'(1));
    check("add_rsp_c", 32'(bus.rsp_c), 32'(16'h8000));
    check("add_rsp_flags", 32'(bus.rsp_flags), 32'(5'b00100));
    check("add_rsp_id", 32'(bus.rsp_id), 32'(0));
    check("add_psr", 32'(bus.psr), 32'(5'b00100));
    bus.rsp_ready = 1'b1;
    tick();
    check("add_done_valid", 32'(bus.rsp_valid), 32'(0));
    check("add_done_busy", 32'(bus.busy), 32'(0));
    bus.rsp_ready = 1'b0;

    // carry chain: ADD sets C, then ADDC consumes it
    issue(1'b0, 16'h0050, 16'hFFFF, 16'h0001, 1'b0, 1'b1, "addff");
    get_rsp("addff", c, f, id);
    check("addff_c", 32'(c), 32'(16'h0000));
    check("addff_flags", 32'(f), 32'(5'b11000));
    check("addff_psr", 32'(bus.psr), 32'(5'b11000));
    issue(1'b1, 16'h0070, 16'h0000, 16'h0000, 1'b1, 1'b0, "addc");
    get_rsp("addc", c, f, id);
    check("addc_c", 32'(c), 32'(16'h0001));
    check("addc_id", 32'(id), 32'(1));
    check("addc_psr", 32'(bus.psr), 32'(5'b11000));

    // CMP 3 vs 5 without flag write
    issue(1'b0, 16'h00B0, 16'h0003, 16'h0005, 1'b0, 1'b0, "cmp");
    get_rsp("cmp", c, f, id);
    check("cmp_flags", 32'(f), 32'(5'b00011));
    check("cmp_psr", 32'(bus.psr), 32'(5'b11000));

    // undefined opcode with wr_flags=1 must not touch psr
    issue(1'b0, 16'h0000, 16'h7FFF, 16'h0001, 1'b0, 1'b1, "undef");
    get_rsp("undef", c, f, id);
    check("undef_c", 32'(c), 32'(16'h0000));
    check("undef_flags", 32'(f), 32'(5'b00000));
    check("undef_psr", 32'(bus.psr), 32'(5'b11000));

    // response back-pressure for 5 cycles
    issue(1'b0, 16'h0010, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, "stall");
    bus.req1_op = 16'h0020; bus.req1_a = 16'h00FF; bus.req1_b = 16'h0F0F;
    bus.req1_wr_flags = 1'b0; bus.req1_use_cin = 1'b0; bus.req1_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid", 32'(bus.rsp_valid), 32'(1));
      check("stall_c", 32'(bus.rsp_c), 32'(16'h000F));
      check("stall_id", 32'(bus.rsp_id), 32'(0));
      check("stall_ready0", 32'(bus.req0_ready), 32'(0));
      check("stall_ready1", 32'(bus.req1_ready), 32'(0));
      check("stall_busy", 32'(bus.busy), 32'(1));
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("stall_6th_valid", 32'(bus.rsp_valid), 32'(1));
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    check("stall_idle_busy", 32'(bus.busy), 32'(0));
    check("stall_idle_ready1", 32'(bus.req1_ready), 32'(1));
    bus.req1_valid = 1'b0;
    tick();
    check("dropped_valid_busy", 32'(bus.busy), 32'(0));

    // reset during EXEC drops the operation and restores PSR_INIT
    issue(1'b0, 16'h0050, 16'hFFFF, 16'h0001, 1'b0, 1'b1, "rstx");
    reset_n = 1'b0;
    tick();
    check("rstx_valid", 32'(bus.rsp_valid), 32'(0));
    check("rstx_busy", 32'(bus.busy), 32'(0));
    check("rstx_psr", 32'(bus.psr), 32'(0));
    reset_n = 1'b1;
    tick(); tick();
    check("rstx_no_rsp", 32'(bus.rsp_valid), 32'(0));

    // round-robin with both requesters held valid
    bus.req0_op = 16'h0010; bus.req0_a = 16'h00FF; bus.req0_b = 16'h0F0F;
    bus.req0_wr_flags = 1'b0; bus.req0_use_cin = 1'b0; bus.req0_valid = 1'b1;
    bus.req1_op = 16'h0020; bus.req1_a = 16'h00FF; bus.req1_b = 16'h0F0F;
    bus.req1_wr_flags = 1'b0; bus.req1_use_cin = 1'b0; bus.req1_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(1'b0, "rr");
      check("rr_id", 32'(bus.rsp_id), 32'(k % 2));
      check("rr_c", 32'(bus.rsp_c), (k % 2 == 1) ? 32'(16'h0FFF) : 32'(16'h000F));
      tick();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;

    // fixed priority instance, held in reset until now
    check("fix_rst_psr", 32'(bus2.psr), 32'(5'b01000));
    check("fix_rst_ready0", 32'(bus2.req0_ready), 32'(0));
    reset2_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_rsp(1'b1, "fix");
      check("fix_id", 32'(bus2.rsp_id), 32'(0));
      check("fix_c", 32'(bus2.rsp_c), 32'(16'h000F));
      tick();
    end
    check("fix_psr", 32'(bus2.psr), 32'(5'b01000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FAIR, default 1: 1 = round-robin arbitration, 0 = fixed priority with req0 winning.
REQ-002 SHALL have parameter PSR_INIT, default 5'b00000: reset value of the flag register.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 reqK_valid  in  1  (K=0,1) request present.
REQ-006 reqK_ready  out  1  request accepted this cycle.
REQ-007 reqK_a, reqK_b  in  16  operands.
REQ-008 reqK_op  in  16  ALU opcode word, same encoding as the ALU.
REQ-009 reqK_use_cin  in  1  drive ALU Cin from PSR carry (bit 3); else Cin=0.
REQ-010 reqK_wr_flags  in  1  commit the result flags to PSR.
REQ-011 rsp_valid  out  1  response held.
REQ-012 rsp_ready  in  1  consumer accepts the response.
REQ-013 rsp_id  out  1  index of the requester that owns the response.
REQ-014 rsp_c  out  16  result.
REQ-015 rsp_flags  out  5  ZCVNL flags of this op.
REQ-016 psr  out  5  committed flag register.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, EXEC and RESP.
REQ-019 IDLE: grant is computed combinationally from the valid inputs; reqK_ready = (state==IDLE) & grantK; on accept, latch a/b/op/use_cin/wr_flags/id and go to EXEC.
REQ-020 The round-robin policy (FAIR=1) SHALL grant the requester that was not granted last when both are valid; last_grant resets to 1, so req0 wins first.
REQ-021 Under fixed priority (FAIR=0), req0 SHALL always win when both are valid.
REQ-022 Only one request SHALL be accepted per cycle.
REQ-023 A request accepted in cycle T SHALL have EXEC in T+1 and rsp_valid high from T+2; the minimum issue interval is 3 cycles.
REQ-024 EXEC: the ALU SHALL be driven from the latched operands, with Cin = latched use_cin & psr[3].
REQ-025 EXEC: rsp_c, rsp_flags and rsp_id SHALL be registered, and the block SHALL go to RESP.
REQ-026 EXEC: psr SHALL be updated with the ALU flags only if wr_flags=1.
REQ-027 An opcode outside the defined set (NOP/WAIT) SHALL produce rsp_c=16'h0000 and rsp_flags=5'b00000, and SHALL NOT update psr even if wr_flags=1.
REQ-028 RESP: rsp_valid=1 with payload stable until rsp_valid & rsp_ready; IDLE in the next cycle.
REQ-029 If rsp_ready is already high on the first RESP cycle, the transfer SHALL complete in that cycle.
REQ-030 Requesters SHALL hold valid and payload stable until ready; a valid that drops before ready is ignored with no side effects.
REQ-031 psr SHALL change only on an EXEC edge or on reset.

Reset
REQ-032 When reset_n=0 at an edge: state=IDLE, rsp_valid=0, rsp_c=0, rsp_flags=0, rsp_id=0, psr=PSR_INIT, last_grant=1, busy=0.
REQ-033 Reset in EXEC or RESP SHALL drop the in-flight operation with no response.
REQ-034 While reset_n=0, reqK_ready SHALL be 0.

Structure
REQ-035 A shared package SHALL hold the opcode constants, flag bit indices (Z=4, C=3, V=2, N=1, L=0), the FSM state encoding and an is_defined_op function.
REQ-036 The ALU SHALL be instantiated as the sole sub-module; alu_arbiter adds no arithmetic of its own.

Verification
REQ-037 req0 ADD (op 16'h0050) a=7FFF b=0001 wr_flags=1 -> rsp_valid at T+2, rsp_c=8000, rsp_flags=00100, psr=00100.
REQ-038 Both valid from reset: req0 AND (0010) 00FF&0F0F, req1 OR (0020) same operands, held -> responses are id0 000F, then id1 0FFF, then alternating.
REQ-039 ADD FFFF+0001 wr_flags=1 -> rsp_c=0000, flags 11000; then ADDC (0070) 0+0 use_cin=1 -> rsp_c=0001.
REQ-040 CMP (00B0) a=0003 b=0005 wr_flags=0 -> rsp_flags=00011, psr unchanged.
REQ-041 rsp_ready low for 5 cycles in RESP -> rsp payload stable, both ready=0, busy=1; accept on the 6th cycle, IDLE next.
REQ-042 reset_n low during EXEC -> next cycle rsp_valid=0, psr=PSR_INIT, state IDLE; a subsequent request completes normally.
